mem_port_arbiter: RTL and testbench

Shares port A of the system dual-port RAM between two requesters: requester 0 is the CPU and requester 1 is a secondary master such as a vector load/store unit or DMA. It grants at most one access per cycle using round-robin, with a bounded lock for bursts. It routes read data back to the originator after the RAM's fixed read latency. It sits between the requesters and the RAM port A pins; port B (video refresh) is untouched.

---
 rtl/mem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares RAM port A between the CPU (requester 0) and a
// secondary master (requester 1). Round-robin grant with a bounded lock for
// bursts, zero-latency grant, and read-data routing after RD_LAT cycles.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req0/1, we0/1, lock0/1      request, write enable, lock request
//   addr0/1, wdata0/1           requester address and write data
//   gnt0/1                      combinational grant (access issued this cycle)
//   rvalid0/1, rdata0/1         registered read-valid, read data (= ram_dout)
//   ram_w, ram_addr, ram_din    RAM port A write enable, address, write data
//   ram_dout                    RAM port A read data
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_w,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned CNT_W = 8;

    // Arbitration state
    logic             last_q,     last_d;
    logic             lock_act_q, lock_act_d;
    logic             lock_id_q,  lock_id_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    // Read-return tag pipeline, one-hot per stage: bit 0 = req0, bit 1 = req1
    logic [1:0] tag_q [RD_LAT];
    logic [1:0] tag_d [RD_LAT];

    logic gnt0_c, gnt1_c;
    logic any_gnt_c, gid_c, other_wait_c, g_lock_c, lock_wins_c, pick_c;

    // Grant selection; gated by reset so nothing is issued while in reset
    always_comb begin
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        lock_wins_c = lock_act_q && (lock_cnt_q < CNT_W'(LOCK_MAX));
        pick_c      = lock_wins_c ? lock_id_q : ~last_q;
        if (!reset) begin
            if (req0 && !req1) begin
                gnt0_c = 1'b1;
            end else if (req1 && !req0) begin
                gnt1_c = 1'b1;
            end else if (req0 && req1) begin
                gnt0_c = ~pick_c;
                gnt1_c = pick_c;
            end
        end
    end

    assign gnt0 = gnt0_c;
    assign gnt1 = gnt1_c;

    // RAM port mux; requester 0 operands pass through when idle, never a write
    assign ram_w    = gnt1_c ? we1 : (gnt0_c & we0);
    assign ram_addr = gnt1_c ? addr1  : addr0;
    assign ram_din  = gnt1_c ? wdata1 : wdata0;

    // Next-state: last winner, lock holder and bounded lock counter
    always_comb begin
        any_gnt_c    = gnt0_c | gnt1_c;
        gid_c        = gnt1_c;
        other_wait_c = gid_c ? req0 : req1;
        g_lock_c     = gid_c ? lock1 : lock0;

        last_d     = last_q;
        lock_act_d = 1'b0;
        lock_id_d  = lock_id_q;
        lock_cnt_d = '0;

        if (any_gnt_c) begin
            last_d = gid_c;
            if (g_lock_c) begin
                lock_act_d = 1'b1;
                lock_id_d  = gid_c;
                // Same holder keeps counting; a new holder starts fresh
                if (lock_act_q && (lock_id_q == gid_c)) begin
                    lock_cnt_d = lock_cnt_q + {{(CNT_W-1){1'b0}}, other_wait_c};
                end else begin
                    lock_cnt_d = {{(CNT_W-1){1'b0}}, other_wait_c};
                end
            end
        end

        tag_d[0] = {gnt1_c & ~we1, gnt0_c & ~we0};
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // State registers; reset discards any in-flight read tags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q     <= 1'b1;
            lock_act_q <= 1'b0;
            lock_id_q  <= 1'b0;
            lock_cnt_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_q[i] <= 2'b00;
            end
        end else begin
            last_q     <= last_d;
            lock_act_q <= lock_act_d;
            lock_id_q  <= lock_id_d;
            lock_cnt_q <= lock_cnt_d;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign rvalid0 = tag_q[RD_LAT-1][0];
    assign rvalid1 = tag_q[RD_LAT-1][1];
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, lock-bound and
// reset-mid-read sequences, then constrained-random traffic against a
// behavioural reference model. Includes a write-first RAM with 1-cycle read.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 32;
    localparam int unsigned RL = 1;
    localparam int unsigned LM = 16;

    logic          clk;
    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_w;
    logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_w(ram_w), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment RAM: write-first, registered read output
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (ram_w) begin
            ram_mem[ram_addr] <= ram_din;
            ram_dout          <= ram_din;
        end else begin
            ram_dout <= ram_mem[ram_addr];
        end
    end

    // ---------------- reference model ----------------
    int            m_last, m_holder, m_cnt, exp_rv, cur_g;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] ref_mem [int];
    int            n_pass, n_total;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic int model_grant();
        if (req0 && !req1) return 0;
        if (req1 && !req0) return 1;
        if (req0 && req1) begin
            if (m_holder >= 0 && m_cnt < int'(LM)) return m_holder;
            return 1 - m_last;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 1; m_holder = -1; m_cnt = 0; exp_rv = -1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Drive inputs mid-cycle and let combinational outputs settle
    task automatic apply(input bit r0, input bit r1, input bit w0, input bit w1,
                         input bit l0, input bit l1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(negedge clk);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1; lock0 = l0; lock1 = l1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        #1;
    endtask

    // Compare every DUT output with the model for the current cycle
    task automatic model_check();
        logic exp_w;
        cur_g = model_grant();
        exp_w = (cur_g == 0) ? we0 : (cur_g == 1) ? we1 : 1'b0;
        chk("gnt0", 64'(gnt0), 64'(cur_g == 0));
        chk("gnt1", 64'(gnt1), 64'(cur_g == 1));
        chk("ram_w", 64'(ram_w), 64'(exp_w));
        chk("ram_addr", 64'(ram_addr), 64'((cur_g == 1) ? addr1 : addr0));
        if (exp_w) chk("ram_din", 64'(ram_din), 64'((cur_g == 1) ? wdata1 : wdata0));
        chk("rvalid0", 64'(rvalid0), 64'(exp_rv == 0));
        chk("rvalid1", 64'(rvalid1), 64'(exp_rv == 1));
        if (exp_rv == 0) chk("rdata0", 64'(rdata0), 64'(exp_rd));
        if (exp_rv == 1) chk("rdata1", 64'(rdata1), 64'(exp_rd));
    endtask

    // Clock edge: update model memory, read-return and lock bookkeeping
    task automatic advance();
        int  a;
        bit  w, lk, ow;
        @(posedge clk);
        exp_rv = -1;
        if (cur_g < 0) begin
            m_holder = -1; m_cnt = 0;
        end else begin
            w  = (cur_g == 1) ? we1 : we0;
            a  = (cur_g == 1) ? int'(addr1) : int'(addr0);
            lk = (cur_g == 1) ? lock1 : lock0;
            ow = (cur_g == 1) ? req0 : req1;
            if (w) ref_mem[a] = (cur_g == 1) ? wdata1 : wdata0;
            else begin exp_rv = cur_g; exp_rd = ref_rd(a); end
            m_last = cur_g;
            if (!lk) begin
                m_holder = -1; m_cnt = 0;
            end else if (m_holder == cur_g) begin
                m_cnt = m_cnt + (ow ? 1 : 0);
            end else begin
                m_holder = cur_g; m_cnt = ow ? 1 : 0;
            end
        end
    endtask

    task automatic step(input bit r0, input bit r1, input bit w0, input bit w1,
                        input bit l0, input bit l1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        apply(r0, r1, w0, w1, l0, l1, a0, a1, d0, d1);
        model_check();
        advance();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        #1;
        chk("rst_gnt0", 64'(gnt0), 64'(0));
        chk("rst_gnt1", 64'(gnt1), 64'(0));
        chk("rst_ram_w", 64'(ram_w), 64'(0));
        chk("rst_rvalid0", 64'(rvalid0), 64'(0));
        chk("rst_rvalid1", 64'(rvalid1), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        bit            eg0, eg1, ew;
        logic [AW-1:0] ea;
        bit            erv0, erv1;
        logic [DW-1:0] erd;
    } vec_t;

    vec_t tbl [13];

    initial begin
        bit            p0, p1, pw0, pw1;
        logic [AW-1:0] pa0, pa1;
        logic [DW-1:0] pd0, pd1;

        n_pass = 0; n_total = 0;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        model_reset();
        do_reset();

        // Preload RAM through requester 0 writes
        for (int i = 0; i < 16; i++) begin
            step(1, 0, 1, 0, 0, 0, AW'(i), '0,
                 (i == 5) ? 32'h5 : (i == 6) ? 32'h6 : 32'h1000 + 32'(i), '0);
        end
        step(1, 0, 1, 0, 0, 0, 19'h10,  '0, 32'hDEADBEEF, '0);
        step(1, 0, 1, 0, 0, 0, 19'h100, '0, 32'hA1, '0);
        step(1, 0, 1, 0, 0, 0, 19'h200, '0, 32'hB2, '0);
        do_reset();

        //            r0 r1 w0 w1 a0       a1        d0 d1            g0 g1 w  ea        v0 v1 rdata
        tbl[0]  = '{1, 1, 0, 0, 19'h100, 19'h200,   0, 0,            1, 0, 0, 19'h100,   0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 19'h100, 19'h200,   0, 0,            0, 1, 0, 19'h200,   1, 0, 32'hA1};
        tbl[2]  = '{1, 1, 0, 0, 19'h100, 19'h200,   0, 0,            1, 0, 0, 19'h100,   0, 1, 32'hB2};
        tbl[3]  = '{1, 1, 0, 0, 19'h100, 19'h200,   0, 0,            0, 1, 0, 19'h200,   1, 0, 32'hA1};
        tbl[4]  = '{0, 0, 0, 0, 19'h0,   19'h0,     0, 0,            0, 0, 0, 19'h0,     0, 1, 32'hB2};
        tbl[5]  = '{1, 0, 0, 0, 19'h10,  19'h0,     0, 0,            1, 0, 0, 19'h10,    0, 0, 0};
        tbl[6]  = '{0, 0, 0, 0, 19'h0,   19'h0,     0, 0,            0, 0, 0, 19'h0,     1, 0, 32'hDEADBEEF};
        tbl[7]  = '{1, 0, 0, 0, 19'h5,   19'h0,     0, 0,            1, 0, 0, 19'h5,     0, 0, 0};
        tbl[8]  = '{0, 1, 0, 0, 19'h0,   19'h6,     0, 0,            0, 1, 0, 19'h6,     1, 0, 32'h5};
        tbl[9]  = '{0, 0, 0, 0, 19'h0,   19'h0,     0, 0,            0, 0, 0, 19'h0,     0, 1, 32'h6};
        tbl[10] = '{0, 1, 0, 1, 19'h0,   19'h7FFFF, 0, 32'h12345678, 0, 1, 1, 19'h7FFFF, 0, 0, 0};
        tbl[11] = '{1, 0, 0, 0, 19'h7FFFF, 19'h0,   0, 0,            1, 0, 0, 19'h7FFFF, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 19'h0,   19'h0,     0, 0,            0, 0, 0, 19'h0,     1, 0, 32'h12345678};

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i].r0, tbl[i].r1, tbl[i].w0, tbl[i].w1, 0, 0,
                  tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
            chk($sformatf("vec%0d_gnt0", i), 64'(gnt0), 64'(tbl[i].eg0));
            chk($sformatf("vec%0d_gnt1", i), 64'(gnt1), 64'(tbl[i].eg1));
            chk($sformatf("vec%0d_ram_w", i), 64'(ram_w), 64'(tbl[i].ew));
            chk($sformatf("vec%0d_ram_addr", i), 64'(ram_addr), 64'(tbl[i].ea));
            chk($sformatf("vec%0d_rvalid0", i), 64'(rvalid0), 64'(tbl[i].erv0));
            chk($sformatf("vec%0d_rvalid1", i), 64'(rvalid1), 64'(tbl[i].erv1));
            if (tbl[i].erv0) chk($sformatf("vec%0d_rdata0", i), 64'(rdata0), 64'(tbl[i].erd));
            if (tbl[i].erv1) chk($sformatf("vec%0d_rdata1", i), 64'(rdata1), 64'(tbl[i].erd));
            model_check();
            advance();
        end

        // Lock bound: requester 1 takes the lock alone, then holds it against req0
        do_reset();
        apply(0, 1, 0, 0, 0, 1, 19'h20, 19'h30, 0, 0);
        chk("lock_take_gnt1", 64'(gnt1), 64'(1));
        model_check(); advance();
        for (int i = 0; i < int'(LM); i++) begin
            apply(1, 1, 0, 0, 0, 1, 19'h20, 19'h30, 0, 0);
            chk($sformatf("lock_hold%0d_gnt1", i), 64'(gnt1), 64'(1));
            model_check(); advance();
        end
        apply(1, 1, 0, 0, 0, 1, 19'h20, 19'h30, 0, 0);
        chk("lock_release_gnt0", 64'(gnt0), 64'(1));
        model_check(); advance();
        apply(1, 1, 0, 0, 0, 1, 19'h20, 19'h30, 0, 0);
        chk("lock_after_gnt1", 64'(gnt1), 64'(1));
        model_check(); advance();

        // Reset mid-read: read granted to requester 0, reset before it returns
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 19'h10, 19'h0, 0, 0);
        chk("midrst_gnt0", 64'(gnt0), 64'(1));
        #1 reset = 1'b1;
        #1;
        chk("midrst_gnt0_off", 64'(gnt0), 64'(0));
        chk("midrst_ram_w", 64'(ram_w), 64'(0));
        model_reset();
        @(posedge clk); #1;
        chk("midrst_rvalid0", 64'(rvalid0), 64'(0));
        chk("midrst_rvalid1", 64'(rvalid1), 64'(0));
        chk("midrst_gnt1_off", 64'(gnt1), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        req0 = 0;
        #1 chk("midrst_post_rvalid0", 64'(rvalid0), 64'(0));
        apply(1, 1, 0, 0, 0, 0, 19'h1, 19'h2, 0, 0);
        chk("midrst_first_contention_gnt0", 64'(gnt0), 64'(1));
        model_check(); advance();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Constrained random: requests held until the model grants them
        p0 = 0; p1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int c = 0; c < 600; c++) begin
            if (!p0 && ($urandom % 3 != 0)) begin
                p0 = 1; pw0 = 1'($urandom % 2); pa0 = AW'($urandom % 16); pd0 = $urandom;
            end
            if (!p1 && ($urandom % 3 != 0)) begin
                p1 = 1; pw1 = 1'($urandom % 2); pa1 = AW'($urandom % 16); pd1 = $urandom;
            end
            apply(p0, p1, pw0, pw1, ($urandom % 4) != 0, ($urandom % 4) != 0,
                  pa0, pa1, pd0, pd1);
            model_check();
            if (cur_g == 0) p0 = 0;
            if (cur_g == 1) p1 = 0;
            advance();
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
